ysyx_25030081_alu_arbiter: RTL and testbench
============================================

# ysyx_25030081_alu_arbiter

Shares one ALU between two requesters: port 0 (EXU) and port 1 (LSU address generation). Each port has a valid/ready request channel and a valid/ready response channel. One request is granted per cycle. The ALU is instantiated internally and evaluated combinationally on the granted operands, and the result is captured in a single response register. The response is then held until the owning port consumes it.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width (only 32 supported)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle when valid & ready
- req0_op / req1_op  in  4  ALU operation code (ALU encoding: 0000 add, 1000 sub, 0010 xor, 0011 sll, 0100 slt, 0101 or, 0111 and, 1010 srl, 1100 sltu, 1110 sra, 0001 pass op2)
- req0_op1 / req1_op1  in  DATA_WIDTH  first operand
- req0_op2 / req1_op2  in  DATA_WIDTH  second operand
- resp0_valid / resp1_valid  out  1  response for port 0 / 1 held in the register
- resp0_ready / resp1_ready  in  1  port consumes its response
- resp_result  out  DATA_WIDTH  registered ALU result (shared by both ports)
- resp_zero  out  1  registered ALU zero flag
- resp_less  out  1  registered ALU less flag

## Operation
- State: `slot_full`, `slot_owner` (0/1), `prio` (port with priority on a tie), and the result/zero/less registers.
- Grant (combinational):
  - only one valid → that port;
  - both valid → port `prio`.
- `drain` = slot_full & resp{slot_owner}_ready.
- `can_accept` = !slot_full | drain.
- reqN_ready = (grant == N) & reqN_valid & can_accept. At most one ready is high in any cycle.
- ALU inputs are muxed from the granted port. On accept: result/zero/less are loaded, slot_owner ← grant, slot_full ← 1.
- On drain without accept: slot_full ← 0, and result/zero/less keep their value.
- respN_valid = slot_full & (slot_owner == N). The non-owner's resp_ready is ignored.
- Priority update on an accept with both ports valid: prio ← ~grant (round-robin). Without contention, prio is unchanged.
- Requester rules:
  - operands stay stable while valid & !ready;
  - valid must not depend on ready;
  - a requester must not drop valid before it is accepted.
- Arithmetic, flags and shift amount (op2[4:0]) are exactly those of the shared ALU. No additional checking. Unlisted opcodes produce whatever the ALU mux outputs (0).

## Timing
- Reset (rst_n low at a clock edge):
  - slot_full = 0, slot_owner = 0, prio = 0;
  - resp_result = 0, resp_zero = 0, resp_less = 0;
  - resp0_valid = resp1_valid = 0. req*_ready is low while rst_n is low.
- A reset during a pending response discards it. No response is delivered for that request.
- Latency: accepted at edge N, respN_valid high in cycle N+1.
- Throughput: one request per cycle, because drain and accept happen in the same cycle. Port 0 result at N+1 can be drained at N+1 while port 1 is accepted at N+1.
- Back-pressure: while slot_full & !resp{owner}_ready, both req_ready are low, and response outputs are held stable.
- Same-port drain and accept in the same cycle: slot_owner is unchanged, the new result replaces the old one, and respN_valid stays high.

## Configuration
- Macro: `YSYX_25030081_ALU_ARB_RR_EN`.
- Defined: round-robin contention resolution as described.
- Undefined: fixed priority. On a tie, port 0 always wins. The prio register is removed (constant 0).
- All other behaviour is identical.

## Test plan
- Reset, then single request on port 0 (op 0000, 5, 7) → req0_ready=1 in the same cycle; next cycle resp0_valid=1, result=12, zero=0, less=0; resp1_valid=0.
- Port 1 sub (op 1000, 3, 3) with resp1_ready=0 for 3 cycles → resp1_valid is held for 3 cycles, result=0, zero=1. A port 0 request during the hold sees req0_ready=0.
- Both ports valid for 4 consecutive requests each, resp ready always high:
  - with RR_EN, grants alternate 0,1,0,1…, one accept per cycle;
  - without RR_EN, all port 0 requests complete before any port 1 request.
- sltu (op 1100, 1, 0xFFFFFFFF) on port 0 → result=1, less=1. slt (op 0100, 0xFFFFFFFF, 1) → result=1.
- Port 0 response pending, rst_n pulsed low for one cycle → resp0_valid=0, result=0. The following request is served normally with latency 1.
- Back-to-back on port 0 with resp0_ready=1: xor (0x0F, 0xFF) then srl (0x80, 4) on consecutive cycles → results 0xF0 and 0x08 on consecutive cycles, resp0_valid continuously high.

Source files
------------

// File: rtl/ysyx_25030081_alu_arbiter.sv
// ysyx_25030081_alu_arbiter
//   Shares one combinational ALU between two requesters (port 0 = EXU,
//   port 1 = LSU address generation). One request is granted per cycle.
//   The granted operands go through the ALU, and the result is captured in
//   a single response slot. The slot is held until the owning port consumes
//   it. A drain and an accept can happen in the same cycle, so the block
//   sustains one request per cycle.
//
// Configuration macro:
//   YSYX_25030081_ALU_ARB_RR_EN
//     defined   : round-robin tie break (prio flips after a contended accept)
//     undefined : fixed priority, port 0 wins every tie
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   reqN_valid/ready         request handshake, port N
//   reqN_op/op1/op2          ALU opcode and operands, port N
//   respN_valid/ready        response handshake, port N
//   resp_result/zero/less    registered ALU outputs, shared by both ports

module ysyx_25030081_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  less
);
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1110;
  localparam logic [3:0] OP_PASS = 4'b0001;

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = op2[4:0];
  assign lt_s  = $signed(op1) < $signed(op2);
  assign lt_u  = op1 < op2;

  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD:  result = op1 + op2;
      OP_SUB:  result = op1 - op2;
      OP_XOR:  result = op1 ^ op2;
      OP_SLL:  result = op1 << shamt;
      OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      OP_OR:   result = op1 | op2;
      OP_AND:  result = op1 & op2;
      OP_SRL:  result = op1 >> shamt;
      OP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, lt_u};
      OP_SRA:  result = $signed(op1) >>> shamt;
      OP_PASS: result = op2;
      default: result = '0;
    endcase
  end

  // less only carries a compare outcome for the set-less-than ops;
  // for every other op it reads 0.
  always_comb begin
    less = 1'b0;
    if (op == OP_SLT)  less = lt_s;
    if (op == OP_SLTU) less = lt_u;
  end

  assign zero = (result == '0);
endmodule

module ysyx_25030081_alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [3:0]            req0_op,
  input  logic [DATA_WIDTH-1:0] req0_op1,
  input  logic [DATA_WIDTH-1:0] req0_op2,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [3:0]            req1_op,
  input  logic [DATA_WIDTH-1:0] req1_op1,
  input  logic [DATA_WIDTH-1:0] req1_op2,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic                  resp_zero,
  output logic                  resp_less
);
  typedef struct packed {
    logic [3:0]            op;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
  } alu_req_t;

  logic [1:0] req_valid;
  logic [1:0] resp_ready;
  logic [1:0] req_ready;
  alu_req_t   req [2];
  alu_req_t   sel;

  assign req_valid  = {req1_valid, req0_valid};
  assign resp_ready = {resp1_ready, resp0_ready};
  assign req[0]     = '{op: req0_op, op1: req0_op1, op2: req0_op2};
  assign req[1]     = '{op: req1_op, op1: req1_op1, op2: req1_op2};

  logic slot_full;
  logic slot_owner;
  logic prio;
  logic grant;
  logic both;
  logic drain;
  logic can_accept;
  logic accept;

  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;
  logic                  alu_less;

  // Grant: a lone requester wins outright, a tie goes to prio.
  assign both  = &req_valid;
  assign grant = both ? prio : req_valid[1];

  // The slot frees up in the same cycle its owner consumes it, which is
  // what allows a new accept every cycle.
  assign drain      = slot_full & resp_ready[slot_owner];
  assign can_accept = ~slot_full | drain;

  // Gated by rst_n so no request is taken while the slot is being cleared.
  assign req_ready[0] = rst_n & ~grant & req_valid[0] & can_accept;
  assign req_ready[1] = rst_n &  grant & req_valid[1] & can_accept;
  assign accept       = |req_ready;

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  assign sel = req[grant];

  ysyx_25030081_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op     (sel.op),
    .op1    (sel.op1),
    .op2    (sel.op2),
    .result (alu_result),
    .zero   (alu_zero),
    .less   (alu_less)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_full   <= 1'b0;
      slot_owner  <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_less   <= 1'b0;
    end else if (accept) begin
      // Covers the same-cycle drain+accept case too: the new result
      // simply overwrites the one being consumed.
      slot_full   <= 1'b1;
      slot_owner  <= grant;
      resp_result <= alu_result;
      resp_zero   <= alu_zero;
      resp_less   <= alu_less;
    end else if (drain) begin
      slot_full   <= 1'b0;
    end
  end

`ifdef YSYX_25030081_ALU_ARB_RR_EN
  // Flip priority only after a contended accept, so an uncontested
  // stream does not disturb the round-robin order.
  always_ff @(posedge clk) begin
    if (!rst_n)
      prio <= 1'b0;
    else if (accept && both)
      prio <= ~grant;
  end
`else
  assign prio = 1'b0;
`endif

  assign resp0_valid = slot_full & ~slot_owner;
  assign resp1_valid = slot_full &  slot_owner;
endmodule

// File: tb/tb_ysyx_25030081_alu_arbiter.sv
// Directed bench for ysyx_25030081_alu_arbiter. Inputs change 1ns after the
// rising edge. Outputs are sampled on the falling edge.
module tb_ysyx_25030081_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0] resp_result;
  logic        resp_zero, resp_less;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_25030081_alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_less(resp_less)
  );

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = 4'h0; req0_op1 = '0; req0_op2 = '0;
    req1_valid = 1'b0; req1_op = 4'h0; req1_op1 = '0; req1_op2 = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    next_cycle(); next_cycle();
    req0_valid = 1'b1;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0 got %b exp 0", req0_ready); end
    checks++; if ({resp0_valid, resp1_valid} !== 2'b00) begin errors++; $display("FAIL rst_resp_valid got %b exp 00", {resp0_valid, resp1_valid}); end
    checks++; if ({resp_result, resp_zero, resp_less} !== 34'd0) begin errors++; $display("FAIL rst_resp got %h/%b/%b exp 0/0/0", resp_result, resp_zero, resp_less); end
    next_cycle();
    req0_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    req0_valid = 1'b1; req0_op = 4'b0000; req0_op1 = 32'd5; req0_op2 = 32'd7;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL add_ready got %b exp 1", req0_ready); end
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++; if ({resp0_valid, resp1_valid} !== 2'b10) begin errors++; $display("FAIL add_valid got %b exp 10", {resp0_valid, resp1_valid}); end
    checks++; if ({resp_result, resp_zero, resp_less} !== {32'd12, 2'b00}) begin errors++; $display("FAIL add_resp got %h/%b/%b exp 0000000c/0/0", resp_result, resp_zero, resp_less); end
    next_cycle();
  endtask

  task automatic test_backpressure();
    resp1_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 4'b1000; req1_op1 = 32'd3; req1_op2 = 32'd3;
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b exp 1", req1_ready); end
    next_cycle();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 4'b0000; req0_op1 = 32'd1; req0_op2 = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0) begin errors++; $display("FAIL bp_hold_valid[%0d] got %b%b exp 01", i, resp0_valid, resp1_valid); end
      checks++; if (resp_result !== 32'd0 || resp_zero !== 1'b1) begin errors++; $display("FAIL bp_hold_resp[%0d] got %h/%b exp 0/1", i, resp_result, resp_zero); end
      checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_block0[%0d] got %b exp 0", i, req0_ready); end
      next_cycle();
    end
    // Port 1 consumes; port 0 is accepted in the same cycle.
    resp1_ready = 1'b1;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_release0 got %b exp 1", req0_ready); end
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++; if ({resp0_valid, resp1_valid} !== 2'b10 || resp_result !== 32'd2) begin errors++; $display("FAIL bp_after got %b%b/%h exp 10/00000002", resp0_valid, resp1_valid, resp_result); end
    next_cycle();
  endtask

  task automatic test_contention();
    int exp_g [8];
    int n0 = 0;
    int n1 = 0;
    int prev_g = -1;
    logic [31:0] prev_r = '0;
`ifdef YSYX_25030081_ALU_ARB_RR_EN
    exp_g = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    req0_op = 4'b0001; req1_op = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      req0_valid = (n0 < 4); req0_op2 = 32'h10 + n0;
      req1_valid = (n1 < 4); req1_op2 = 32'h20 + n1;
      @(negedge clk);
      checks++; if ({req1_ready, req0_ready} !== (exp_g[k] == 1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_grant[%0d] got %b%b exp port %0d", k, req1_ready, req0_ready, exp_g[k]); end
      if (prev_g >= 0) begin
        checks++; if ({resp1_valid, resp0_valid} !== (prev_g == 1 ? 2'b10 : 2'b01) || resp_result !== prev_r) begin errors++; $display("FAIL cont_resp[%0d] got %b%b/%h exp port %0d/%h", k, resp1_valid, resp0_valid, resp_result, prev_g, prev_r); end
      end
      prev_g = exp_g[k];
      prev_r = (exp_g[k] == 1) ? 32'h20 + n1 : 32'h10 + n0;
      if (req0_ready) n0++;
      else if (req1_ready) n1++;
      next_cycle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    checks++; if ({resp1_valid, resp0_valid} !== 2'b10 || resp_result !== prev_r) begin errors++; $display("FAIL cont_last got %b%b/%h exp 10/%h", resp1_valid, resp0_valid, resp_result, prev_r); end
    next_cycle();
  endtask

  task automatic test_compare();
    req0_valid = 1'b1; req0_op = 4'b1100; req0_op1 = 32'd1; req0_op2 = 32'hFFFF_FFFF;
    @(negedge clk);
    next_cycle();
    req0_op = 4'b0100; req0_op1 = 32'hFFFF_FFFF; req0_op2 = 32'd1;
    @(negedge clk);
    checks++; if ({resp_result, resp_zero, resp_less} !== {32'd1, 2'b01}) begin errors++; $display("FAIL sltu got %h/%b/%b exp 00000001/0/1", resp_result, resp_zero, resp_less); end
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL slt_ready got %b exp 1", req0_ready); end
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++; if ({resp_result, resp_zero, resp_less} !== {32'd1, 2'b01}) begin errors++; $display("FAIL slt got %h/%b/%b exp 00000001/0/1", resp_result, resp_zero, resp_less); end
    next_cycle();
  endtask

  task automatic test_reset_pending();
    resp0_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 4'b0000; req0_op1 = 32'd2; req0_op2 = 32'd3;
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (resp0_valid !== 1'b1 || resp_result !== 32'd5) begin errors++; $display("FAIL rp_pending got %b/%h exp 1/00000005", resp0_valid, resp_result); end
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({resp0_valid, resp1_valid} !== 2'b00 || resp_result !== 32'd0) begin errors++; $display("FAIL rp_cleared got %b%b/%h exp 00/0", resp0_valid, resp1_valid, resp_result); end
    next_cycle();
    resp0_ready = 1'b1;
    req0_valid = 1'b1; req0_op1 = 32'd4; req0_op2 = 32'd4;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rp_ready got %b exp 1", req0_ready); end
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (resp0_valid !== 1'b1 || resp_result !== 32'd8) begin errors++; $display("FAIL rp_after got %b/%h exp 1/00000008", resp0_valid, resp_result); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    req0_valid = 1'b1; req0_op = 4'b0010; req0_op1 = 32'h0F; req0_op2 = 32'hFF;
    @(negedge clk);
    next_cycle();
    req0_op = 4'b1010; req0_op1 = 32'h80; req0_op2 = 32'd4;
    @(negedge clk);
    checks++; if (resp0_valid !== 1'b1 || resp_result !== 32'hF0) begin errors++; $display("FAIL b2b_xor got %b/%h exp 1/000000f0", resp0_valid, resp_result); end
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", req0_ready); end
    next_cycle();
    req0_op = 4'b1110; req0_op1 = 32'h8000_0000; req0_op2 = 32'd4;
    @(negedge clk);
    checks++; if (resp0_valid !== 1'b1 || resp_result !== 32'h08) begin errors++; $display("FAIL b2b_srl got %b/%h exp 1/00000008", resp0_valid, resp_result); end
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++; if ({resp0_valid, resp_result, resp_zero, resp_less} !== {1'b1, 32'hF800_0000, 2'b00}) begin errors++; $display("FAIL b2b_sra got %b/%h/%b/%b exp 1/f8000000/0/0", resp0_valid, resp_result, resp_zero, resp_less); end
    next_cycle();
    @(negedge clk);
    checks++; if ({resp0_valid, resp1_valid} !== 2'b00) begin errors++; $display("FAIL b2b_drained got %b%b exp 00", resp0_valid, resp1_valid); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_add();
    test_backpressure();
    test_contention();
    test_compare();
    test_reset_pending();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
